// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register for the 5-stage MIPS datapath.
// Define EX_MUL_EN to add the 32-cycle iterative multiplier (funct 011000).
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  wb_ctl,
    input  logic [2:0]  m_ctl,
    input  logic [3:0]  ex_ctl,
    input  logic [31:0] npc,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [31:0] s_extend,
    input  logic [4:0]  instr_2016,
    input  logic [4:0]  instr_1511,
    output logic [1:0]  wb_ctlout,
    output logic [2:0]  m_ctlout,
    output logic [31:0] add_result,
    output logic        zero,
    output logic [31:0] alu_result,
    output logic [31:0] rdata2out,
    output logic [4:0]  muxout,
    output logic        out_valid
);

    logic        regdst;
    logic [1:0]  aluop;
    logic        alusrc;
    logic [31:0] opb;
    logic [31:0] alu_val;
    logic [31:0] branch_tgt;
    logic [4:0]  dst;

    assign {regdst, aluop, alusrc} = ex_ctl;

    always_comb begin
        opb     = alusrc ? s_extend : rdata2;
        alu_val = '0;
        case (aluop)
            2'b00: alu_val = rdata1 + opb;
            2'b01: alu_val = rdata1 - opb;
            2'b10: begin
                case (s_extend[5:0])
                    6'b100000: alu_val = rdata1 + opb;
                    6'b100010: alu_val = rdata1 - opb;
                    6'b100100: alu_val = rdata1 & opb;
                    6'b100101: alu_val = rdata1 | opb;
                    6'b101010: alu_val = {31'b0, $signed(rdata1) < $signed(opb)};
                    default:   alu_val = '0;
                endcase
            end
            default: alu_val = '0;
        endcase
    end

    assign branch_tgt = npc + {s_extend[29:0], 2'b00};
    assign dst        = regdst ? instr_1511 : instr_2016;

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [1:0]  mul_wb;
    logic [2:0]  mul_m;
    logic [4:0]  mul_dst;
    logic [31:0] mul_add;
    logic [31:0] mul_rd2;
    logic        is_mult;

    assign is_mult  = (aluop == 2'b10) && (s_extend[5:0] == 6'b011000);
    assign in_ready = !rst && !stall && (state == IDLE);
`else
    assign in_ready = !rst && !stall;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ctlout  <= '0;
            m_ctlout   <= '0;
            add_result <= '0;
            zero       <= 1'b0;
            alu_result <= '0;
            rdata2out  <= '0;
            muxout     <= '0;
            out_valid  <= 1'b0;
`ifdef EX_MUL_EN
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            mul_wb     <= '0;
            mul_m      <= '0;
            mul_dst    <= '0;
            mul_add    <= '0;
            mul_rd2    <= '0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
            wb_ctlout <= '0;
            m_ctlout  <= '0;
`ifdef EX_MUL_EN
            state     <= IDLE;
        end else if (state == MUL) begin
            // Low 32 bits only: the multiplicand shifts out of range harmlessly.
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31)
                state <= DONE;
        end else if (state == DONE) begin
            if (!stall) begin
                wb_ctlout  <= mul_wb;
                m_ctlout   <= mul_m;
                add_result <= mul_add;
                alu_result <= acc;
                zero       <= (acc == '0);
                rdata2out  <= mul_rd2;
                muxout     <= mul_dst;
                out_valid  <= 1'b1;
                state      <= IDLE;
            end
`endif
        end else if (!stall) begin
            add_result <= branch_tgt;
            alu_result <= alu_val;
            zero       <= (alu_val == '0);
            rdata2out  <= rdata2;
            muxout     <= dst;
            out_valid  <= in_valid;
            wb_ctlout  <= in_valid ? wb_ctl : '0;
            m_ctlout   <= in_valid ? m_ctl : '0;
`ifdef EX_MUL_EN
            // An accepted multiply leaves a bubble behind and parks its fields.
            if (in_valid && is_mult) begin
                out_valid <= 1'b0;
                wb_ctlout <= '0;
                m_ctlout  <= '0;
                state     <= MUL;
                cnt       <= '0;
                acc       <= '0;
                mcand     <= rdata1;
                mplier    <= opb;
                mul_wb    <= wb_ctl;
                mul_m     <= m_ctl;
                mul_dst   <= dst;
                mul_add   <= branch_tgt;
                mul_rd2   <= rdata2;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic [3:0]  ex_ctl;
    logic [31:0] npc, rdata1, rdata2, s_extend;
    logic [4:0]  instr_2016, instr_1511;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [31:0] add_result;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2out;
    logic [4:0]  muxout;
    logic        out_valid;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
        .ex_ctl(ex_ctl), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
        .s_extend(s_extend), .instr_2016(instr_2016), .instr_1511(instr_1511),
        .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .add_result(add_result),
        .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
        .muxout(muxout), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        bit          cd;
        logic        v;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] alu;
        logic [31:0] add;
        logic [31:0] rd2;
        logic        z;
        logic [4:0]  mux;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    exp_t le;
    exp_t me;
    int   ncyc  = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        while (q.size() > 0 && q[0].cyc <= ncyc) begin
            me = q.pop_front();
            chk({me.name, ".valid"}, {31'b0, out_valid}, {31'b0, me.v});
            chk({me.name, ".wb"}, {30'b0, wb_ctlout}, {30'b0, me.wb});
            chk({me.name, ".m"}, {29'b0, m_ctlout}, {29'b0, me.m});
            chk({me.name, ".in_ready"}, {31'b0, in_ready}, {31'b0, me.rdy});
            if (me.cd) begin
                chk({me.name, ".alu"}, alu_result, me.alu);
                chk({me.name, ".add"}, add_result, me.add);
                chk({me.name, ".rd2"}, rdata2out, me.rd2);
                chk({me.name, ".zero"}, {31'b0, zero}, {31'b0, me.z});
                chk({me.name, ".mux"}, {27'b0, muxout}, {27'b0, me.mux});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [1:0] wb, input logic [2:0] m,
                       input logic [3:0] ex, input logic [31:0] np, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] se,
                       input logic [4:0] rt, input logic [4:0] rd);
        in_valid = v; wb_ctl = wb; m_ctl = m; ex_ctl = ex; npc = np;
        rdata1 = r1; rdata2 = r2; s_extend = se; instr_2016 = rt; instr_1511 = rd;
    endtask

    task automatic push(input string nm, input bit cd, input logic v, input logic [1:0] wb,
                        input logic [2:0] m, input logic [31:0] alu, input logic [31:0] add,
                        input logic [31:0] rd2, input logic z, input logic [4:0] mux,
                        input logic rdy);
        exp_t e;
        e.cyc = ncyc + 1; e.name = nm; e.cd = cd; e.v = v; e.wb = wb; e.m = m;
        e.alu = alu; e.add = add; e.rd2 = rd2; e.z = z; e.mux = mux; e.rdy = rdy;
        le = e;
        q.push_back(e);
    endtask

    task automatic push_hold(input string nm);
        exp_t h;
        h = le;
        h.cyc = ncyc + 1; h.name = nm; h.rdy = 1'b0;
        q.push_back(h);
    endtask

    task automatic bubbles(input int n, input string nm, input logic rdy);
        for (int i = 0; i < n; i++) begin
            push(nm, 1'b0, 1'b0, 2'b00, 3'b000, '0, '0, '0, 1'b0, 5'd0, rdy);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drv(1'b0, 2'b00, 3'b000, 4'b0000, '0, '0, '0, '0, 5'd0, 5'd0);
        tick();
        push("reset", 1'b1, 1'b0, 2'b00, 3'b000, '0, '0, '0, 1'b0, 5'd0, 1'b0);
        tick();
        rst = 1'b0;

        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd7, 32'h20, 5'd3, 5'd9);
        push("r_add", 1'b1, 1'b1, 2'b10, 3'b000, 32'd12, 32'h84, 32'd7, 1'b0, 5'd9, 1'b1); tick();
        drv(1'b1, 2'b11, 3'b010, 4'b0001, 32'h40, 32'h100, 32'h55, 32'hFFFFFFFC, 5'd4, 5'd0);
        push("lw", 1'b1, 1'b1, 2'b11, 3'b010, 32'hFC, 32'h30, 32'h55, 1'b0, 5'd4, 1'b1); tick();
        drv(1'b1, 2'b00, 3'b100, 4'b0010, 32'h100, 32'h1234, 32'h1234, 32'h3, 5'd5, 5'd1);
        push("beq", 1'b1, 1'b1, 2'b00, 3'b100, 32'h0, 32'h10C, 32'h1234, 1'b1, 5'd5, 1'b1); tick();
        flush = 1'b1;
        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h8, 32'hF0F0, 32'hFF00, 32'h24, 5'd2, 5'd10);
        push("flush", 1'b0, 1'b0, 2'b00, 3'b000, '0, '0, '0, 1'b0, 5'd0, 1'b1); tick();
        flush = 1'b0;
        push("and", 1'b1, 1'b1, 2'b10, 3'b000, 32'hF000, 32'h98, 32'hFF00, 1'b0, 5'd10, 1'b1); tick();
        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h8, 32'hF0F0, 32'h0F0F, 32'h25, 5'd2, 5'd10);
        push("or", 1'b1, 1'b1, 2'b10, 3'b000, 32'hFFFF, 32'h9C, 32'h0F0F, 1'b0, 5'd10, 1'b1); tick();
        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h8, 32'hFFFFFFFF, 32'h1, 32'h2A, 5'd2, 5'd10);
        push("slt_neg", 1'b1, 1'b1, 2'b10, 3'b000, 32'h1, 32'hB0, 32'h1, 1'b0, 5'd10, 1'b1); tick();
        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h8, 32'h1, 32'hFFFFFFFF, 32'h2A, 5'd2, 5'd10);
        push("slt_pos", 1'b1, 1'b1, 2'b10, 3'b000, 32'h0, 32'hB0, 32'hFFFFFFFF, 1'b1, 5'd10, 1'b1); tick();
        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h8, 32'd3, 32'd5, 32'h22, 5'd2, 5'd10);
        push("r_sub", 1'b1, 1'b1, 2'b10, 3'b000, 32'hFFFFFFFE, 32'h90, 32'd5, 1'b0, 5'd10, 1'b1); tick();
        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h8, 32'd3, 32'd5, 32'h3F, 5'd2, 5'd10);
        push("bad_funct", 1'b1, 1'b1, 2'b10, 3'b000, 32'h0, 32'h104, 32'd5, 1'b1, 5'd10, 1'b1); tick();
        drv(1'b1, 2'b10, 3'b000, 4'b1110, 32'h8, 32'd1, 32'd1, 32'h20, 5'd2, 5'd10);
        push("aluop11", 1'b1, 1'b1, 2'b10, 3'b000, 32'h0, 32'h88, 32'd1, 1'b1, 5'd10, 1'b1); tick();
        drv(1'b0, 2'b11, 3'b111, 4'b1100, 32'h8, 32'd1, 32'd1, 32'h20, 5'd2, 5'd10);
        push("bubble", 1'b0, 1'b0, 2'b00, 3'b000, '0, '0, '0, 1'b0, 5'd0, 1'b1); tick();
        drv(1'b1, 2'b01, 3'b000, 4'b0000, 32'h14, 32'hFFFFFFFF, 32'd2, 32'h0, 5'd2, 5'd10);
        push("wrap", 1'b1, 1'b1, 2'b01, 3'b000, 32'h1, 32'h14, 32'd2, 1'b0, 5'd2, 1'b1); tick();

        drv(1'b1, 2'b01, 3'b001, 4'b1100, 32'hC, 32'd100, 32'd23, 32'h20, 5'd2, 5'd11);
        push("pre_stall", 1'b1, 1'b1, 2'b01, 3'b001, 32'd123, 32'h8C, 32'd23, 1'b0, 5'd11, 1'b1); tick();
        stall = 1'b1;
        drv(1'b1, 2'b10, 3'b010, 4'b0010, 32'h10, 32'd50, 32'd8, 32'h0, 5'd6, 5'd12);
        for (int i = 0; i < 3; i++) begin
            push_hold("stall_hold"); tick();
        end
        stall = 1'b0;
        push("post_stall", 1'b1, 1'b1, 2'b10, 3'b010, 32'd42, 32'h10, 32'd8, 1'b0, 5'd6, 1'b1); tick();
        stall = 1'b1; flush = 1'b1;
        push("flush_over_stall", 1'b0, 1'b0, 2'b00, 3'b000, '0, '0, '0, 1'b0, 5'd0, 1'b0); tick();
        stall = 1'b0; flush = 1'b0;

`ifdef EX_MUL_EN
        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h20, 32'h10000, 32'h10001, 32'h18, 5'd3, 5'd7);
        bubbles(33, "mul_busy", 1'b0);
        push("mul_done", 1'b1, 1'b1, 2'b10, 3'b000, 32'h10000, 32'h80, 32'h10001, 1'b0, 5'd7, 1'b1); tick();
        drv(1'b0, 2'b00, 3'b000, 4'b0000, '0, '0, '0, '0, 5'd0, 5'd0);
        bubbles(1, "mul_after", 1'b1);

        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h20, 32'h10000, 32'h10001, 32'h18, 5'd3, 5'd7);
        bubbles(33, "mul2_busy", 1'b0);
        stall = 1'b1;
        bubbles(2, "mul2_done_stall", 1'b0);
        stall = 1'b0;
        push("mul2_done", 1'b1, 1'b1, 2'b10, 3'b000, 32'h10000, 32'h80, 32'h10001, 1'b0, 5'd7, 1'b1); tick();
        drv(1'b0, 2'b00, 3'b000, 4'b0000, '0, '0, '0, '0, 5'd0, 5'd0);
        bubbles(1, "mul2_after", 1'b1);

        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h20, 32'h10000, 32'h10001, 32'h18, 5'd3, 5'd7);
        bubbles(10, "mul3_busy", 1'b0);
        flush = 1'b1;
        bubbles(1, "mul3_flush", 1'b1);
        flush = 1'b0;
        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd7, 32'h20, 5'd3, 5'd9);
        push("mul3_next", 1'b1, 1'b1, 2'b10, 3'b000, 32'd12, 32'h84, 32'd7, 1'b0, 5'd9, 1'b1); tick();

        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h20, 32'h10000, 32'h10001, 32'h18, 5'd3, 5'd7);
        bubbles(5, "mul4_busy", 1'b0);
`else
        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h20, 32'h10000, 32'h10001, 32'h18, 5'd3, 5'd7);
        push("mult_off", 1'b1, 1'b1, 2'b10, 3'b000, 32'h0, 32'h80, 32'h10001, 1'b1, 5'd7, 1'b1); tick();
`endif
        #2 rst = 1'b1;
        #1;
        chk("arst.valid", {31'b0, out_valid}, 32'h0);
        chk("arst.wb", {30'b0, wb_ctlout}, 32'h0);
        chk("arst.m", {29'b0, m_ctlout}, 32'h0);
        chk("arst.add", add_result, 32'h0);
        chk("arst.alu", alu_result, 32'h0);
        chk("arst.rd2", rdata2out, 32'h0);
        chk("arst.mux", {27'b0, muxout}, 32'h0);
        chk("arst.zero", {31'b0, zero}, 32'h0);
        chk("arst.in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        rst = 1'b0;
        drv(1'b1, 2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd7, 32'h20, 5'd3, 5'd9);
        push("post_rst", 1'b1, 1'b1, 2'b10, 3'b000, 32'd12, 32'h84, 32'd7, 1'b0, 5'd9, 1'b1); tick();
        drv(1'b0, 2'b00, 3'b000, 4'b0000, '0, '0, '0, '0, 5'd0, 5'd0);
        bubbles(1, "post_rst_idle", 1'b1);

        tick();
        tick();
        chk("queue_drained", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
